// File: rtl/demux_router.sv
// rtl/demux_router.sv - buffered lane router: in-order FIFO feeding a 4-lane demux with per-lane backpressure
module demux_router #(
  parameter int DATA_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [3:0]            pausa,
  output logic                  full,
  output logic                  empty,
  output logic                  enb,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            selector_out,
  output logic [1:0]            estado,
  output logic                  error
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVO = 2'b01,
    PAUSA  = 2'b10
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] head;
  logic [1:0]            head_lane;
  logic                  push_ok;
  logic                  pop;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  assign head_lane = head[DATA_WIDTH-1:DATA_WIDTH-2];
  assign push_ok   = push && !full;
  // Only the registered head is eligible, so a word written this edge can never bypass.
  assign pop       = !empty && !pausa[head_lane];
  assign enb       = (state == ACTIVO);
  assign estado    = state;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      selector_out <= '0;
      error        <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr       <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        data_out     <= head;
        selector_out <= head_lane;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A drop is judged on the pre-edge full flag, so a same-edge pop cannot rescue it.
      if (push && full) begin
        error <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    if (pop) begin
      next_state = ACTIVO;
    end else if (!empty) begin
      next_state = PAUSA;
    end
  end

endmodule
